// File: rtl/bc_game_ctrl_pkg.sv
// Shared types, one-hot score codes and BCD helpers for the Bulls & Cows
// round controller.
package bc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_COMPARE,
      ST_RESULT,
      ST_WIN,
      ST_LOSE
   } bc_state_e;

   localparam logic [2:0] BC_ZERO = 3'b001;
   localparam logic [2:0] BC_ONE  = 3'b010;
   localparam logic [2:0] BC_TWO  = 3'b100;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic bcd_digit_ok(input logic [3:0] d);
      return d <= BCD_MAX;
   endfunction

   function automatic logic bcd_pair_ok(input logic [7:0] v);
      return bcd_digit_ok(v[7:4]) && bcd_digit_ok(v[3:0]);
   endfunction

endpackage

// File: rtl/bc_game_ctrl_if.sv
// Game-side bus of the round controller: secret/guess requests in,
// compare-stage operands and scores, and display status out.
interface bc_game_ctrl_if;
   logic       set_secret;
   logic [7:0] secret_in;
   logic       guess_valid;
   logic [7:0] guess_in;
   logic [2:0] bulls;
   logic [2:0] cows;
   logic [7:0] cmp_a;
   logic [7:0] cmp_b;
   logic       ready;
   logic [3:0] attempts;
   logic [1:0] last_bulls;
   logic [1:0] last_cows;
   logic       win;
   logic       lose;
   logic       err;

   modport master (
      output set_secret, secret_in, guess_valid, guess_in, bulls, cows,
      input  cmp_a, cmp_b, ready, attempts, last_bulls, last_cows, win, lose, err
   );

   modport slave (
      input  set_secret, secret_in, guess_valid, guess_in, bulls, cows,
      output cmp_a, cmp_b, ready, attempts, last_bulls, last_cows, win, lose, err
   );
endinterface

// File: rtl/bc_game_ctrl_onehot2bin.sv
// Decodes a one-hot bulls/cows code (001/010/100) to a binary count and
// flags any code that is not exactly one-hot.
module bc_onehot2bin
   import bc_pkg::*;
(
   input  logic [2:0] onehot_i,
   output logic [1:0] count_o,
   output logic       illegal_o
);

   always_comb begin
      count_o   = 2'd0;
      illegal_o = 1'b0;
      case (onehot_i)
         BC_ZERO: count_o = 2'd0;
         BC_ONE:  count_o = 2'd1;
         BC_TWO:  count_o = 2'd2;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/bc_game_ctrl.sv
// Round controller for two-digit Bulls & Cows: holds secret and guess for
// the compare stage, scores returned codes, counts attempts, decides win/lose.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no secret loaded yet; guesses ignored
// ST_ARMED   | secret loaded, waiting for a guess (ready = 1)
// ST_COMPARE | guess on cmp_b; bulls/cows sampled at end of this cycle
// ST_RESULT  | score committed; decide win / lose / next guess
// ST_WIN     | last guess scored two bulls; hold until a new secret
// ST_LOSE    | MAX_TRIES guesses used without a win; hold until a new secret
module bc_game_ctrl
   import bc_pkg::*;
#(
   parameter int MAX_TRIES = 8
) (
   input  logic           clk,
   input  logic           rst,
   bc_game_ctrl_if.slave  bus
);

   localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

   bc_state_e  state_q;
   logic [7:0] cmp_a_q;
   logic [7:0] cmp_b_q;
   logic [3:0] attempts_q;
   logic [3:0] attempts_d;
   logic [1:0] last_bulls_q;
   logic [1:0] last_cows_q;
   logic       ready_q;
   logic       win_q;
   logic       lose_q;
   logic       err_q;

   logic [1:0] bulls_cnt;
   logic [1:0] cows_cnt;
   logic       bulls_ill;
   logic       cows_ill;
   logic       secret_ok;
   logic       guess_ok;
   logic       secret_take;

   bc_onehot2bin u_bulls_dec (
      .onehot_i  (bus.bulls),
      .count_o   (bulls_cnt),
      .illegal_o (bulls_ill)
   );

   bc_onehot2bin u_cows_dec (
      .onehot_i  (bus.cows),
      .count_o   (cows_cnt),
      .illegal_o (cows_ill)
   );

   assign secret_ok   = bcd_pair_ok(bus.secret_in) && (bus.secret_in[7:4] != bus.secret_in[3:0]);
   assign guess_ok    = bcd_pair_ok(bus.guess_in);
   assign attempts_d  = attempts_q + 4'd1;
   // A scoring round in flight cannot be interrupted by a new secret.
   assign secret_take = bus.set_secret && (state_q != ST_COMPARE) && (state_q != ST_RESULT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cmp_a_q      <= 8'h00;
         cmp_b_q      <= 8'h00;
         attempts_q   <= 4'd0;
         last_bulls_q <= 2'd0;
         last_cows_q  <= 2'd0;
         ready_q      <= 1'b0;
         win_q        <= 1'b0;
         lose_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (secret_take) begin
            // Takes priority over a coincident guess, which is dropped.
            if (secret_ok) begin
               cmp_a_q      <= bus.secret_in;
               attempts_q   <= 4'd0;
               last_bulls_q <= 2'd0;
               last_cows_q  <= 2'd0;
               win_q        <= 1'b0;
               lose_q       <= 1'b0;
               ready_q      <= 1'b1;
               state_q      <= ST_ARMED;
            end else begin
               err_q <= 1'b1;
            end
         end else begin
            case (state_q)
               ST_ARMED: begin
                  if (bus.guess_valid) begin
                     if (guess_ok) begin
                        cmp_b_q <= bus.guess_in;
                        ready_q <= 1'b0;
                        state_q <= ST_COMPARE;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               ST_COMPARE: begin
                  if (bulls_ill || cows_ill) begin
                     err_q   <= 1'b1;
                     ready_q <= 1'b1;
                     state_q <= ST_ARMED;
                  end else begin
                     last_bulls_q <= bulls_cnt;
                     last_cows_q  <= cows_cnt;
                     attempts_q   <= attempts_d;
                     state_q      <= ST_RESULT;
                  end
               end
               ST_RESULT: begin
                  if (last_bulls_q == 2'd2) begin
                     win_q   <= 1'b1;
                     state_q <= ST_WIN;
                  end else if (attempts_q == MAX_T) begin
                     lose_q  <= 1'b1;
                     state_q <= ST_LOSE;
                  end else begin
                     ready_q <= 1'b1;
                     state_q <= ST_ARMED;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.cmp_a      = cmp_a_q;
   assign bus.cmp_b      = cmp_b_q;
   assign bus.ready      = ready_q;
   assign bus.attempts   = attempts_q;
   assign bus.last_bulls = last_bulls_q;
   assign bus.last_cows  = last_cows_q;
   assign bus.win        = win_q;
   assign bus.lose       = lose_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_bc_game_ctrl.sv
// Bench for bc_game_ctrl: directed game scenarios followed by random play,
// checked against a transaction-level game model.
module tb_bc_game_ctrl;

   localparam int MAX_T = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bc_game_ctrl_if bif ();

   bc_game_ctrl #(.MAX_TRIES(MAX_T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Compare stage stand-in, with an override to inject illegal codes.
   logic       force_en = 1'b0;
   logic [2:0] force_code = 3'b000;

   function automatic logic [1:0] n_bulls(input logic [7:0] s, input logic [7:0] g);
      int b = 0;
      if (s[7:4] == g[7:4]) b++;
      if (s[3:0] == g[3:0]) b++;
      return 2'(b);
   endfunction

   function automatic logic [1:0] n_cows(input logic [7:0] s, input logic [7:0] g);
      int c = 0;
      if (g[7:4] == s[3:0]) c++;
      if (g[3:0] == s[7:4]) c++;
      return 2'(c);
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] n);
      return 3'b001 << n;
   endfunction

   assign bif.bulls = force_en ? force_code : onehot(n_bulls(bif.cmp_a, bif.cmp_b));
   assign bif.cows  = onehot(n_cows(bif.cmp_a, bif.cmp_b));

   // Expected observable state of the game.
   logic [7:0] e_cmp_a, e_cmp_b;
   logic [3:0] e_att;
   logic [1:0] e_lb, e_lc;
   logic       e_ready, e_win, e_lose, e_err;

   function automatic bit secret_ok(input logic [7:0] s);
      return (s[7:4] <= 9) && (s[3:0] <= 9) && (s[7:4] != s[3:0]);
   endfunction

   function automatic bit guess_ok(input logic [7:0] g);
      return (g[7:4] <= 9) && (g[3:0] <= 9);
   endfunction

   task automatic model_reset();
      e_cmp_a = 8'h00; e_cmp_b = 8'h00; e_att = 4'd0; e_lb = 2'd0; e_lc = 2'd0;
      e_ready = 1'b0; e_win = 1'b0; e_lose = 1'b0; e_err = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, "/cmp_a"},      bif.cmp_a,      e_cmp_a);
      chk({tag, "/cmp_b"},      bif.cmp_b,      e_cmp_b);
      chk({tag, "/attempts"},   bif.attempts,   e_att);
      chk({tag, "/last_bulls"}, bif.last_bulls, e_lb);
      chk({tag, "/last_cows"},  bif.last_cows,  e_lc);
      chk({tag, "/ready"},      bif.ready,      e_ready);
      chk({tag, "/win"},        bif.win,        e_win);
      chk({tag, "/lose"},       bif.lose,       e_lose);
      chk({tag, "/err"},        bif.err,        e_err);
   endtask

   task automatic idle_tick();
      tick();
      e_err = 1'b0;
      chk_all("hold");
   endtask

   task automatic load_secret(input logic [7:0] s, input bit with_guess, input logic [7:0] g);
      bif.set_secret = 1'b1; bif.secret_in = s;
      bif.guess_valid = with_guess; bif.guess_in = g;
      tick();
      bif.set_secret = 1'b0; bif.guess_valid = 1'b0;
      e_err = 1'b0;
      if (secret_ok(s)) begin
         e_cmp_a = s; e_att = 4'd0; e_lb = 2'd0; e_lc = 2'd0;
         e_win = 1'b0; e_lose = 1'b0; e_ready = 1'b1;
      end else begin
         e_err = 1'b1;
      end
      chk_all("load");
   endtask

   task automatic do_guess(input logic [7:0] g, input bit bad_code, input logic [2:0] code, input bit ss_mid);
      bif.guess_valid = 1'b1; bif.guess_in = g;
      tick();
      bif.guess_valid = 1'b0;
      e_err = 1'b0;
      if (!e_ready) begin
         chk_all("ignored");
         return;
      end
      if (!guess_ok(g)) begin
         e_err = 1'b1;
         chk_all("badguess");
         return;
      end
      e_cmp_b = g; e_ready = 1'b0;
      chk_all("compare");
      if (ss_mid) begin bif.set_secret = 1'b1; bif.secret_in = 8'h45; end
      if (bad_code) begin force_en = 1'b1; force_code = code; end
      tick();
      bif.set_secret = 1'b0; force_en = 1'b0;
      if (bad_code) begin
         e_err = 1'b1; e_ready = 1'b1;
         chk_all("illegal");
         return;
      end
      e_lb = n_bulls(e_cmp_a, g); e_lc = n_cows(e_cmp_a, g); e_att = e_att + 4'd1;
      chk_all("result");
      tick();
      if (e_lb == 2'd2) e_win = 1'b1;
      else if (e_att == 4'(MAX_T)) e_lose = 1'b1;
      else e_ready = 1'b1;
      chk_all("decide");
   endtask

   function automatic logic [7:0] rand_secret();
      logic [3:0] a, b;
      if ($urandom_range(0, 4) == 0) return 8'($urandom);
      a = 4'($urandom_range(0, 9));
      b = 4'((int'(a) + $urandom_range(1, 9)) % 10);
      return {a, b};
   endfunction

   function automatic logic [7:0] rand_guess();
      int r = $urandom_range(0, 99);
      logic [7:0] s = e_cmp_a;
      if (r < 10) return 8'($urandom);
      if (r < 25) return s;
      if (r < 40) return {s[3:0], s[7:4]};
      if (r < 55) return {s[7:4], 4'($urandom_range(0, 9))};
      return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
   endfunction

   logic [2:0] illegal_codes [5];

   initial begin
      illegal_codes = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
      rst = 1'b1;
      bif.set_secret = 1'b0; bif.secret_in = 8'h00;
      bif.guess_valid = 1'b0; bif.guess_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk_all("reset");
      #2 rst = 1'b0;

      do_guess(8'h12, 0, 3'b000, 0);
      load_secret(8'h33, 0, 8'h00);
      idle_tick();
      load_secret(8'h3A, 0, 8'h00);
      idle_tick();

      load_secret(8'h37, 0, 8'h00);
      do_guess(8'h73, 0, 3'b000, 0);
      do_guess(8'h37, 0, 3'b000, 0);
      do_guess(8'h12, 0, 3'b000, 0);
      load_secret(8'hAA, 0, 8'h00);
      idle_tick();

      load_secret(8'h37, 0, 8'h00);
      repeat (3) do_guess(8'h12, 0, 3'b000, 0);
      do_guess(8'h12, 0, 3'b000, 0);

      load_secret(8'h37, 0, 8'h00);
      do_guess(8'h12, 0, 3'b000, 0);
      do_guess(8'h33, 0, 3'b000, 0);
      do_guess(8'h37, 0, 3'b000, 0);

      load_secret(8'h37, 0, 8'h00);
      do_guess(8'h12, 1, 3'b011, 0);
      do_guess(8'h1A, 0, 3'b000, 0);
      idle_tick();
      do_guess(8'h12, 0, 3'b000, 1);
      load_secret(8'h45, 1, 8'h54);
      idle_tick();

      // Asynchronous reset while a guess is being compared.
      bif.guess_valid = 1'b1; bif.guess_in = 8'h40;
      tick();
      bif.guess_valid = 1'b0;
      e_err = 1'b0; e_cmp_b = 8'h40; e_ready = 1'b0;
      chk_all("pre_rst");
      #2 rst = 1'b1;
      #1 model_reset();
      chk_all("rst_mid");
      rst = 1'b0;
      idle_tick();

      for (int i = 0; i < 400; i++) begin
         int r = $urandom_range(0, 99);
         if (r < 15) begin
            load_secret(rand_secret(), $urandom_range(0, 3) == 0, rand_guess());
         end else if (r < 19) begin
            @(posedge clk);
            #($urandom_range(1, 7));
            rst = 1'b1;
            #1 model_reset();
            chk_all("rnd_rst");
            rst = 1'b0;
         end else begin
            do_guess(rand_guess(), $urandom_range(0, 9) == 0,
                     illegal_codes[$urandom_range(0, 4)], $urandom_range(0, 9) == 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
